// File: rtl/shake_arb.sv
// Round-robin arbiter that shares one SHAKE core among NREQ requesters.
// Define SHAKE_ARB_WATCHDOG_EN to build the RUN-state watchdog and its sticky err flag.
module shake_arb #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic                    core_done,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_idx,
    output logic                    core_start,
    output logic [NREQ-1:0]         done,
    output logic                    busy,
    output logic                    err
);

    // state   | meaning
    // IDLE    | no grant; arbitrate among pending requests
    // START   | grant loaded, core_start pulsed
    // RUN     | core busy, waiting for core_done (or watchdog)
    // RELEASE | operation over, hold grant until the winner drops req

    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
        $error("shake_arb: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, START, RUN, RELEASE} state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] pick_idx;
    logic          pick_vld;
    logic [IW-1:0] next_ptr;
    logic          wd_timeout;

    // Scan from the highest offset down so the smallest offset from rr_ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(rr_ptr) + i) % NREQ]) begin
                pick_vld = 1'b1;
                pick_idx = IW'((int'(rr_ptr) + i) % NREQ);
            end
        end
    end

    assign next_ptr = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
    assign busy     = (state != IDLE);

`ifdef SHAKE_ARB_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    logic [15:0] wd_cnt;
    logic        err_q;

    // core_done in the same cycle as expiry takes priority over the timeout.
    assign wd_timeout = (state == RUN) && !core_done && (wd_cnt == WD_LAST);
    assign err        = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else if (state == START) begin
            wd_cnt <= '0;
        end else if (state == RUN) begin
            wd_cnt <= wd_cnt + 16'd1;
            if (wd_timeout)
                err_q <= 1'b1;
        end
    end
`else
    assign wd_timeout = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gnt        <= '0;
            gnt_idx    <= '0;
            done       <= '0;
            core_start <= 1'b0;
        end else begin
            done       <= '0;
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt        <= NREQ'(1) << pick_idx;
                        gnt_idx    <= pick_idx;
                        core_start <= 1'b1;
                        state      <= START;
                    end
                end
                START: state <= RUN;
                RUN: begin
                    if (core_done) begin
                        done  <= gnt;
                        state <= RELEASE;
                    end else if (wd_timeout) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    // The core cannot be aborted, so a request dropped early is honoured only here.
                    if (!req[gnt_idx]) begin
                        gnt     <= '0;
                        gnt_idx <= '0;
                        rr_ptr  <= next_ptr;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shake_arb.sv
// Self-checking bench for shake_arb: directed scenarios plus a grant/done scoreboard monitor.
// Build with SHAKE_ARB_WATCHDOG_EN to exercise the watchdog scenario instead of the wait-forever one.
module tb_shake_arb;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic       core_done = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       core_start;
    logic [3:0] done;
    logic       busy;
    logic       err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [1:0] exp_gnt_q[$];
    logic [3:0] exp_done_q[$];
    logic [1:0] mon_idx;
    logic [3:0] mon_done;

    shake_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .core_done  (core_done),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .core_start (core_start),
        .done       (done),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every grant and every done pulse must match the next expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (core_start) begin
                tests_run++;
                if (exp_gnt_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_gnt: unexpected grant gnt=%b", gnt);
                end else begin
                    mon_idx = exp_gnt_q.pop_front();
                    if (gnt !== (4'b0001 << mon_idx) || gnt_idx !== mon_idx) begin
                        tests_failed++;
                        $display("FAIL sb_gnt: got gnt=%b idx=%0d want idx=%0d", gnt, gnt_idx, mon_idx);
                    end
                end
            end
            if (done !== 4'b0000) begin
                tests_run++;
                if (exp_done_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_done: unexpected done=%b", done);
                end else begin
                    mon_done = exp_done_q.pop_front();
                    if (done !== mon_done) begin
                        tests_failed++;
                        $display("FAIL sb_done: got %b want %b", done, mon_done);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "tb_shake_arb timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        core_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Wait for the grant, run the core run_len cycles, then release the winner's request.
    task automatic serve(input logic [1:0] idx, input int run_len, input bit rearm, output int waited);
        waited = 0;
        while (!core_start && waited < 20) begin
            tick();
            waited++;
        end
        tests_run++;
        if (!core_start) begin
            tests_failed++;
            $display("FAIL serve_start_timeout: no core_start for idx %0d", idx);
            req[idx] = 1'b0;
            return;
        end
        if (gnt_idx !== idx) begin
            tests_failed++;
            $display("FAIL serve_idx: got %0d want %0d", gnt_idx, idx);
        end
        exp_done_q.push_back(4'b0001 << idx);
        tick();
        repeat (run_len - 1) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        req[idx] = 1'b0;
        tick();
        tests_run++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL serve_release: got gnt=%b busy=%b want gnt=0000 busy=0", gnt, busy);
        end
        if (rearm) req[idx] = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (gnt !== 4'b0 || gnt_idx !== 2'd0 || done !== 4'b0 || core_start !== 1'b0 ||
            busy !== 1'b0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: gnt=%b idx=%0d done=%b start=%b busy=%b err=%b",
                     gnt, gnt_idx, done, core_start, busy, err);
        end
    endtask

    task automatic test_single();
        req = 4'b0001;
        exp_gnt_q.push_back(2'd0);
        tick();
        tests_run++;
        if (gnt !== 4'b0001 || core_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_c1: got gnt=%b start=%b want 0001/1", gnt, core_start);
        end
        tick();
        tests_run++;
        if (core_start !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_c2: got start=%b busy=%b want 0/1", core_start, busy);
        end
        repeat (8) tick();
        core_done = 1'b1;
        exp_done_q.push_back(4'b0001);
        tick();
        core_done = 1'b0;
        tests_run++;
        if (done !== 4'b0001) begin
            tests_failed++;
            $display("FAIL single_done: got %b want 0001", done);
        end
        tick();
        tests_run++;
        if (done !== 4'b0000 || gnt !== 4'b0001) begin
            tests_failed++;
            $display("FAIL single_hold: got done=%b gnt=%b want 0000/0001", done, gnt);
        end
        req = 4'b0000;
        tick();
        tests_run++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_release: got gnt=%b busy=%b want 0000/0", gnt, busy);
        end
    endtask

    task automatic test_round_robin();
        int w;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_gnt_q.push_back(2'(k % 4));
            if (k == 4) req = 4'b0001;
            serve(2'(k % 4), 3 + k, k < 4, w);
            tests_run++;
            if (w !== 1) begin
                tests_failed++;
                $display("FAIL rr_turnaround: grant %0d came after %0d cycles want 1", k, w);
            end
        end
    endtask

    task automatic test_wrap();
        int w;
        req = 4'b0100;
        exp_gnt_q.push_back(2'd2);
        serve(2'd2, 2, 1'b0, w);
        req = 4'b1001;
        exp_gnt_q.push_back(2'd3);
        serve(2'd3, 2, 1'b0, w);
        exp_gnt_q.push_back(2'd0);
        serve(2'd0, 2, 1'b0, w);
        tests_run++;
        if (w !== 1) begin
            tests_failed++;
            $display("FAIL wrap_turnaround: got %0d cycles want 1", w);
        end
    endtask

    task automatic test_early_drop();
        req = 4'b0010;
        exp_gnt_q.push_back(2'd1);
        tick();
        tick();
        req = 4'b0000;
        repeat (3) tick();
        tests_run++;
        if (gnt !== 4'b0010 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL early_hold: got gnt=%b busy=%b want 0010/1", gnt, busy);
        end
        exp_done_q.push_back(4'b0010);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tests_run++;
        if (done !== 4'b0010) begin
            tests_failed++;
            $display("FAIL early_done: got %b want 0010", done);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            tests_failed++;
            $display("FAIL early_idle: got busy=%b gnt=%b want 0/0000", busy, gnt);
        end
        tick();
        tests_run++;
        if (done !== 4'b0000) begin
            tests_failed++;
            $display("FAIL early_single_pulse: got %b want 0000", done);
        end
    endtask

    task automatic test_stray_done();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 4'b0000) begin
            tests_failed++;
            $display("FAIL stray_idle: got busy=%b done=%b want 0/0000", busy, done);
        end
        req = 4'b0100;
        exp_gnt_q.push_back(2'd2);
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tests_run++;
        if (done !== 4'b0000 || busy !== 1'b1 || gnt !== 4'b0100) begin
            tests_failed++;
            $display("FAIL stray_start: got done=%b busy=%b gnt=%b want 0000/1/0100", done, busy, gnt);
        end
        repeat (3) tick();
        exp_done_q.push_back(4'b0100);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tests_run++;
        if (done !== 4'b0100) begin
            tests_failed++;
            $display("FAIL stray_run_done: got %b want 0100", done);
        end
        req = 4'b0000;
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_release: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        req = 4'b1000;
        exp_gnt_q.push_back(2'd3);
        tick();
        tick();
        tick();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
        tests_run++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000 || core_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: got gnt=%b busy=%b done=%b start=%b want all 0",
                     gnt, busy, done, core_start);
        end
        // rr_ptr must be back at 0, so requester 1 wins over 3.
        req = 4'b1010;
        exp_gnt_q.push_back(2'd1);
        tick();
        req = 4'b0000;
        tick();
        exp_done_q.push_back(4'b0010);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_after: got busy=%b want 0", busy);
        end
    endtask

`ifdef SHAKE_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        do_reset();
        req = 4'b0001;
        exp_gnt_q.push_back(2'd0);
        tick();
        repeat (8) tick();
        tests_run++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL wd_early: got err=%b busy=%b want 0/1", err, busy);
        end
        tick();
        tests_run++;
        if (err !== 1'b1 || done !== 4'b0000 || gnt !== 4'b0001) begin
            tests_failed++;
            $display("FAIL wd_fire: got err=%b done=%b gnt=%b want 1/0000/0001", err, done, gnt);
        end
        req = 4'b0000;
        tick();
        tests_run++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL wd_release: got gnt=%b busy=%b err=%b want 0000/0/1", gnt, busy, err);
        end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL wd_clear: got err=%b want 0", err);
        end
    endtask
`else
    task automatic test_no_watchdog();
        do_reset();
        req = 4'b0010;
        exp_gnt_q.push_back(2'd1);
        tick();
        repeat (20) tick();
        tests_run++;
        if (busy !== 1'b1 || err !== 1'b0 || gnt !== 4'b0010) begin
            tests_failed++;
            $display("FAIL nowd_wait: got busy=%b err=%b gnt=%b want 1/0/0010", busy, err, gnt);
        end
        exp_done_q.push_back(4'b0010);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tests_run++;
        if (done !== 4'b0010) begin
            tests_failed++;
            $display("FAIL nowd_done: got %b want 0010", done);
        end
        req = 4'b0000;
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL nowd_release: got busy=%b want 0", busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_early_drop();
        test_stray_done();
        test_reset_mid();
`ifdef SHAKE_ARB_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        tick();
        tests_run++;
        if (exp_gnt_q.size() != 0 || exp_done_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_drain: got %0d grants %0d dones outstanding want 0/0",
                     exp_gnt_q.size(), exp_done_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/shake_arb.md
SHAKE_ARB -- requirements
Module: shake_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters sharing one SHAKE core (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, giving the watchdog limit in cycles (1..65535).
REQ-003 The block SHALL have port clk  input  1  clock; single clock domain, all logic on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 The block SHALL have port req  input  NREQ  per-requester access request, level, held until its done.
REQ-006 The block SHALL have port core_done  input  1  one-cycle pulse from the SHAKE core marking end of operation.
REQ-007 The block SHALL have port gnt  output  NREQ  one-hot grant, registered, drives the core input mux.
REQ-008 The block SHALL have port gnt_idx  output  $clog2(NREQ)  binary index of the granted requester; 0 when none.
REQ-009 The block SHALL have port core_start  output  1  one-cycle start pulse to the SHAKE core.
REQ-010 The block SHALL have port done  output  NREQ  one-hot one-cycle completion pulse to the granted requester.
REQ-011 The block SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-012 The block SHALL have port err  output  1  sticky watchdog error flag.

Function
REQ-013 The FSM SHALL have states IDLE, START, RUN, RELEASE.
REQ-014 In IDLE with any req bit high, the block SHALL pick the first set bit at or after rr_ptr, wrapping modulo NREQ, load gnt/gnt_idx, and enter START.
REQ-015 gnt SHALL be visible in the cycle after req is sampled, and core_start SHALL be high for exactly that one START cycle.
REQ-016 START SHALL always go to RUN in the next cycle; core_done SHALL be ignored in every state except RUN.
REQ-017 In RUN, core_done SHALL pulse done[gnt_idx] in the next cycle and move the FSM to RELEASE.
REQ-018 In RELEASE, the block SHALL hold gnt until req[gnt_idx] is low, then clear gnt and gnt_idx, set rr_ptr to (gnt_idx+1) mod NREQ, and return to IDLE.
REQ-019 If the granted req drops during START or RUN, the block SHALL keep the grant until core_done, because the core cannot be aborted, then leave RELEASE in its first cycle.
REQ-020 Only one grant SHALL be active at any time; gnt SHALL be zero in IDLE.
REQ-021 The minimum turnaround SHALL be two cycles: a release seen at cycle K gives the next grant no earlier than cycle K+2.
REQ-022 Requests from non-granted requesters SHALL be ignored until IDLE and SHALL NOT disturb gnt.
REQ-023 rr_ptr SHALL only change on release, so that after a winner is served, every other pending requester is served before it again.

Reset
REQ-024 When rst is high at a clock edge, the block SHALL set state=IDLE, rr_ptr=0, gnt=0, gnt_idx=0, done=0, core_start=0, err=0, and clear the watchdog count.
REQ-025 A reset mid-operation SHALL drop the grant at once without a done pulse, and the bench SHALL reset the core in the same cycle.

Configuration
REQ-026 With macro SHAKE_ARB_WATCHDOG_EN defined, a 16-bit counter SHALL clear on entry to RUN and count each RUN cycle.
REQ-027 When that counter reaches TIMEOUT without core_done, the block SHALL set err (cleared only by rst), emit no done pulse, and go to RELEASE.
REQ-028 If core_done and the timeout occur in the same cycle, core_done SHALL win.
REQ-029 With SHAKE_ARB_WATCHDOG_EN undefined, no counter SHALL be built, err SHALL be tied to 0, and RUN SHALL wait indefinitely.

Verification
REQ-030 Single requester: req=0001 at cycle 0 -> gnt=0001 and core_start=1 at cycle 1, core_start=0 at cycle 2; core_done at cycle 10 -> done=0001 at cycle 11; req low at cycle 12 -> gnt=0 at cycle 13.
REQ-031 Round-robin: req=1111 held, each requester releasing after its done -> grant order 0,1,2,3,0; no requester granted twice in a row.
REQ-032 Pointer wrap: rr_ptr=3 and req=1001 -> gnt=1000; after its release with req=0001 -> gnt=0001.
REQ-033 Early drop: the granted req goes low in RUN -> grant holds until core_done, done pulses once, IDLE the cycle after RELEASE.
REQ-034 Stray done: core_done in IDLE or START -> no done pulse and no state change.
REQ-035 Watchdog (macro defined, TIMEOUT=8): no core_done -> err=1 after 8 RUN cycles, done stays 0, grant released; rst -> err=0.
